fft_power_avg: RTL and testbench
================================

Name: fft_power_avg

Overview:
- Downstream consumer of the 256-point FFT core's bit-reversed-corrected output stream (fftr/ffti, qualified by a valid strobe).
- Computes per-bin power re²+im², accumulates it over 2^LOG2_AVG consecutive frames in an internal accumulator RAM, then streams the averaged power spectrum in natural bin order.
- Reports the peak bin and its power once per averaged spectrum.
- Sits between the FFT and the spectrum display/detection logic.

Parameters:
- N, 256, points per frame (power of 2).
- LOG2N, 8, log2(N); width of the bin index.
- W, 16, input sample width (signed).
- LOG2_AVG, 2, log2 of the number of frames averaged (0 = no averaging).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  qualifies xr_in/xi_in for one sample
- xr_in  in  W  signed real part of the FFT bin
- xi_in  in  W  signed imaginary part of the FFT bin
- out_valid  out  1  qualifies out_pow/out_bin
- out_bin  out  LOG2N  bin index of out_pow
- out_pow  out  2W  averaged power, unsigned
- spec_done  out  1  one-cycle pulse after the last readout bin
- peak_bin  out  LOG2N  bin index of the maximum averaged power
- peak_pow  out  2W  maximum averaged power
- in_drop  out  1  sticky flag: a sample arrived during DRAIN/READOUT and was discarded

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: all outputs 0. State ACCUM. Bin counter 0, frame counter 0.
- Accumulator RAM contents are don't-care after reset; no clear pass is needed (see first-frame rule).

Arithmetic:
- pow = xr_in*xr_in + xi_in*xi_in, computed in 2W unsigned bits.
- Maximum value is 2^31 at -32768,-32768; there is no overflow.
- Accumulator width is 2W+LOG2_AVG unsigned.
- Averaged value = acc >> LOG2_AVG (truncating).

State ACCUM:
- Each in_valid cycle is one sample for bin = bin counter. Gaps in in_valid are allowed and ignored.
- Frame 0 writes acc[bin] = pow (no read). Later frames write acc[bin] = acc[bin] + pow.
- Pipeline is 3 cycles: input register, square/sum plus synchronous RAM read, write.
- Consecutive samples always target distinct bins, so there is no read-after-write hazard while N>=4.
- Bin counter increments per accepted sample and wraps N-1→0. On wrap the frame counter increments.
- The sample that completes bin N-1 of frame 2^LOG2_AVG-1 moves the FSM to DRAIN.

State DRAIN:
- Lasts exactly 3 cycles, until the final write retires, then goes to READOUT.

State READOUT:
- Reads acc[0..N-1], one address per cycle.
- out_valid is high for exactly N consecutive cycles; the first comes 2 cycles after entering READOUT.
- out_bin increments 0..N-1.
- Running peak: update when avg > current (strict), so ties keep the lowest bin. The running register starts at 0 with bin 0.

Completion:
- One cycle after the last out_valid: spec_done=1 for one cycle.
- peak_bin/peak_pow are loaded from the running peak in that same cycle and hold until the next spec_done.
- The FSM returns to ACCUM with both counters at 0.

Input during DRAIN/READOUT:
- in_valid samples are discarded and in_drop is set. in_drop clears only on reset.

Reset mid-operation:
- Any state returns to ACCUM with counters 0. The pipeline is flushed: no RAM write occurs in the reset cycle or after it from pre-reset samples.
- out_valid and spec_done drop in the same cycle reset is sampled.

LOG2_AVG=0:
- Each frame writes only (no add) and goes straight to DRAIN/READOUT.

Test Plan:
- Constant re=1000, im=0 on all bins for 4 frames, continuous valid → 256 out_valid cycles, every out_pow=1000000, peak_bin=0, peak_pow=1000000, exactly one spec_done pulse.
- Frames all zero except bin 37 = (-32768,-32768) → out_pow[37]=2147483648, others 0, peak_bin=37, peak_pow=2147483648.
- Bin 5 powers 100, 200, 300, 400 (re=10,√200 approximated: use (10,0), (10,10), (10,14.1→ re=17,im=1 → 290), (20,0)) across frames → out_pow[5]=(100+200+290+400)>>2=247.
- Random in_valid gaps (about 50% duty) with the same data as the first scenario → results identical to the continuous case; out_valid still N back-to-back cycles.
- in_valid asserted during READOUT → in_drop=1, and the output spectrum is unchanged.
- Reset asserted mid-frame 2, then 4 fresh frames of (3,4) → all out_pow=25; no contamination from pre-reset data.

Source files
------------

// File: rtl/fft_power_avg.sv
// Per-bin power averager for the FFT output stream: accumulates |X|^2 over 2^LOG2_AVG frames,
// then streams the averaged spectrum in bin order and reports its peak bin.
module fft_power_avg #(
  parameter int unsigned N        = 256,
  parameter int unsigned LOG2N    = 8,
  parameter int unsigned W        = 16,
  parameter int unsigned LOG2_AVG = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic signed [W-1:0] xr_in,
  input  logic signed [W-1:0] xi_in,
  output logic                out_valid,
  output logic [LOG2N-1:0]    out_bin,
  output logic [2*W-1:0]      out_pow,
  output logic                spec_done,
  output logic [LOG2N-1:0]    peak_bin,
  output logic [2*W-1:0]      peak_pow,
  output logic                in_drop
);

  localparam int unsigned AccW   = 2 * W + LOG2_AVG;
  localparam int unsigned FrameW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [FrameW-1:0] LastFrame = FrameW'((1 << LOG2_AVG) - 1);
  localparam logic [LOG2N-1:0]  LastBin   = LOG2N'(N - 1);
  localparam logic [LOG2N:0]    NumBins   = (LOG2N + 1)'(N);

  typedef enum logic [1:0] {StAccum, StDrain, StReadout} state_e;

  state_e state_q, state_d;

  logic [LOG2N-1:0]  bin_q;
  logic [FrameW-1:0] frame_q;
  logic [1:0]        drain_q;
  logic [LOG2N:0]    rd_addr_q;

  // Accumulate pipeline: s0 = input register, s1 = power + RAM read, then write.
  logic                s0_valid_q, s0_first_q;
  logic signed [W-1:0] s0_xr_q, s0_xi_q;
  logic [LOG2N-1:0]    s0_bin_q;
  logic                s1_valid_q, s1_first_q;
  logic [2*W-1:0]      s1_pow_q;
  logic [LOG2N-1:0]    s1_bin_q;

  logic [AccW-1:0]  mem [N];
  logic [AccW-1:0]  rd_data_q;
  logic [AccW-1:0]  wr_data;
  logic [LOG2N-1:0] raddr;

  logic                 rd_vld_q;
  logic [LOG2N-1:0]     rd_bin_q;
  logic [2*W-1:0]       run_pow_q;
  logic [LOG2N-1:0]     run_bin_q;
  logic                 out_valid_q, spec_done_q, in_drop_q;
  logic [LOG2N-1:0]     out_bin_q, peak_bin_q;
  logic [2*W-1:0]       out_pow_q, peak_pow_q;

  logic                 accept, last_sample, rd_req, readout_end;
  logic signed [2*W-1:0] re_sq, im_sq;
  logic [2*W-1:0]       pow, avg;

  assign accept      = in_valid && (state_q == StAccum);
  assign last_sample = accept && (bin_q == LastBin) && (frame_q == LastFrame);
  assign rd_req      = (state_q == StReadout) && (rd_addr_q < NumBins);
  assign readout_end = (state_q == StReadout) && out_valid_q && (out_bin_q == LastBin);

  assign re_sq = (2 * W)'(s0_xr_q) * (2 * W)'(s0_xr_q);
  assign im_sq = (2 * W)'(s0_xi_q) * (2 * W)'(s0_xi_q);
  assign pow   = $unsigned(re_sq) + $unsigned(im_sq);

  assign wr_data = s1_first_q ? AccW'(s1_pow_q) : rd_data_q + AccW'(s1_pow_q);
  assign raddr   = (state_q == StReadout) ? rd_addr_q[LOG2N-1:0] : s0_bin_q;
  assign avg     = rd_data_q[AccW-1:LOG2_AVG];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum:   if (last_sample) state_d = StDrain;
      StDrain:   if (drain_q == 2'd2) state_d = StReadout;
      StReadout: if (readout_end) state_d = StAccum;
      default:   state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAccum;
      bin_q     <= '0;
      frame_q   <= '0;
      drain_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bin_q <= bin_q + 1'b1;
        if (bin_q == LastBin) begin
          frame_q <= (frame_q == LastFrame) ? '0 : frame_q + 1'b1;
        end
      end
      drain_q <= (state_q == StDrain) ? drain_q + 2'd1 : 2'd0;
      if (rd_req) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end else if (state_q != StReadout) begin
        rd_addr_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s0_first_q <= 1'b0;
      s0_xr_q    <= '0;
      s0_xi_q    <= '0;
      s0_bin_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_pow_q   <= '0;
      s1_bin_q   <= '0;
    end else begin
      s0_valid_q <= accept;
      if (accept) begin
        s0_xr_q    <= xr_in;
        s0_xi_q    <= xi_in;
        s0_bin_q   <= bin_q;
        s0_first_q <= (frame_q == '0);
      end
      s1_valid_q <= s0_valid_q;
      s1_pow_q   <= pow;
      s1_bin_q   <= s0_bin_q;
      s1_first_q <= s0_first_q;
    end
  end

  // No reset on the array; the reset gate keeps in-flight samples from landing.
  always_ff @(posedge clk) begin
    rd_data_q <= mem[raddr];
    if (!reset && s1_valid_q) begin
      mem[s1_bin_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q    <= 1'b0;
      rd_bin_q    <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_pow_q   <= '0;
      run_pow_q   <= '0;
      run_bin_q   <= '0;
      spec_done_q <= 1'b0;
      peak_bin_q  <= '0;
      peak_pow_q  <= '0;
      in_drop_q   <= 1'b0;
    end else begin
      rd_vld_q    <= rd_req;
      rd_bin_q    <= rd_addr_q[LOG2N-1:0];
      out_valid_q <= rd_vld_q;
      if (rd_vld_q) begin
        out_bin_q <= rd_bin_q;
        out_pow_q <= avg;
      end
      // Strict compare keeps the lowest bin on ties.
      if (state_q == StDrain) begin
        run_pow_q <= '0;
        run_bin_q <= '0;
      end else if (rd_vld_q && (avg > run_pow_q)) begin
        run_pow_q <= avg;
        run_bin_q <= rd_bin_q;
      end
      spec_done_q <= readout_end;
      if (readout_end) begin
        peak_bin_q <= run_bin_q;
        peak_pow_q <= run_pow_q;
      end
      in_drop_q <= in_drop_q | (in_valid && (state_q != StAccum));
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_pow   = out_pow_q;
  assign spec_done = spec_done_q;
  assign peak_bin  = peak_bin_q;
  assign peak_pow  = peak_pow_q;
  assign in_drop   = in_drop_q;

endmodule

// File: tb/tb_fft_power_avg.sv
// Directed bench for fft_power_avg: table of averaging scenarios plus drop and mid-frame reset.
module tb_fft_power_avg;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] xr_in, xi_in;
  logic               out_valid;
  logic [7:0]         out_bin;
  logic [31:0]        out_pow;
  logic               spec_done;
  logic [7:0]         peak_bin;
  logic [31:0]        peak_pow;
  logic               in_drop;

  fft_power_avg dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .xr_in     (xr_in),
    .xi_in     (xi_in),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_pow   (out_pow),
    .spec_done (spec_done),
    .peak_bin  (peak_bin),
    .peak_pow  (peak_pow),
    .in_drop   (in_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     scen;
    bit     gaps;
    bit     inject;
    bit     pre_reset;
    int     chk_bin;
    longint exp_chk;
    longint exp_other;
    int     exp_pbin;
    longint exp_ppow;
  } vec_t;

  vec_t vecs [6];

  logic signed [15:0] fr_re [4][256];
  logic signed [15:0] fr_im [4][256];

  logic [31:0] cap_pow [256];
  int          ov_cnt, sd_cnt, run_len, max_run, bad_order;
  logic [7:0]  exp_next;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      cap_pow[out_bin] = out_pow;
      if (out_bin != exp_next) bad_order++;
      exp_next = exp_next + 8'd1;
      ov_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (spec_done) sd_cnt++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    ov_cnt = 0; sd_cnt = 0; run_len = 0; max_run = 0; bad_order = 0; exp_next = 8'd0;
    for (int b = 0; b < 256; b++) cap_pow[b] = 32'hDEADBEEF;
  endtask

  task automatic fill(input int scen);
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 256; b++) begin
        fr_re[f][b] = 16'sd0;
        fr_im[f][b] = 16'sd0;
        case (scen)
          0: fr_re[f][b] = 16'sd1000;
          1: if (b == 37) begin fr_re[f][b] = -16'sd32768; fr_im[f][b] = -16'sd32768; end
          2: if (b == 5) begin
               case (f)
                 0: begin fr_re[f][b] = 16'sd10; fr_im[f][b] = 16'sd0;  end
                 1: begin fr_re[f][b] = 16'sd10; fr_im[f][b] = 16'sd10; end
                 2: begin fr_re[f][b] = 16'sd17; fr_im[f][b] = 16'sd1;  end
                 default: begin fr_re[f][b] = 16'sd20; fr_im[f][b] = 16'sd0; end
               endcase
             end
          4: begin fr_re[f][b] = 16'sd3; fr_im[f][b] = 16'sd4; end
          default: begin fr_re[f][b] = 16'sd100; fr_im[f][b] = 16'sd200; end
        endcase
      end
    end
  endtask

  // Call at a negedge; returns at a negedge with in_valid low.
  task automatic drive(input int nsamp, input bit gaps);
    for (int k = 0; k < nsamp; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      xr_in    = fr_re[k / 256][k % 256];
      xi_in    = fr_im[k / 256][k % 256];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int waited;
    int inj;
    int others_bad;
    if (v.pre_reset) begin
      fill(5);
      @(negedge clk);
      drive(2 * 256 + 128, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_spec_done", spec_done, 0);
      chk("rst_in_drop", in_drop, 0);
      chk("rst_peak_pow", peak_pow, 0);
      reset = 1'b0;
    end
    fill(v.scen);
    @(posedge clk);
    #1;
    clear_mon();
    @(negedge clk);
    drive(4 * 256, v.gaps);
    waited = 0;
    inj    = 0;
    while (sd_cnt == 0 && waited < 3000) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (v.inject && out_valid && inj < 3) begin
        in_valid = 1'b1;
        xr_in    = 16'sd30000;
        xi_in    = 16'sd30000;
        inj++;
      end
      waited++;
    end
    in_valid = 1'b0;
    if (waited >= 3000) begin
      errors++;
      $display("FAIL row%0d timeout: got no spec_done expected one within 3000 cycles", idx);
    end
    repeat (5) @(negedge clk);
    others_bad = 0;
    for (int b = 0; b < 256; b++) begin
      if (b != v.chk_bin && longint'(cap_pow[b]) != v.exp_other) others_bad++;
    end
    $display("row %0d", idx);
    chk("out_valid_count", ov_cnt, 256);
    chk("out_valid_run", max_run, 256);
    chk("spec_done_count", sd_cnt, 1);
    chk("bin_order_errs", bad_order, 0);
    chk("pow_at_chk_bin", cap_pow[v.chk_bin], v.exp_chk);
    chk("other_bins_bad", others_bad, 0);
    chk("peak_bin", peak_bin, v.exp_pbin);
    chk("peak_pow", peak_pow, v.exp_ppow);
    chk("in_drop", in_drop, v.inject);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 0,  64'd1000000,    64'd1000000, 0,  64'd1000000};
    vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 37, 64'd2147483648, 64'd0,       37, 64'd2147483648};
    vecs[2] = '{2, 1'b0, 1'b0, 1'b0, 5,  64'd247,        64'd0,       5,  64'd247};
    vecs[3] = '{0, 1'b1, 1'b0, 1'b0, 0,  64'd1000000,    64'd1000000, 0,  64'd1000000};
    vecs[4] = '{2, 1'b0, 1'b1, 1'b0, 5,  64'd247,        64'd0,       5,  64'd247};
    vecs[5] = '{4, 1'b1, 1'b0, 1'b1, 0,  64'd25,         64'd25,      0,  64'd25};

    reset    = 1'b1;
    in_valid = 1'b0;
    xr_in    = '0;
    xi_in    = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_pow", out_pow, 0);
    chk("reset_spec_done", spec_done, 0);
    chk("reset_peak_pow", peak_pow, 0);
    chk("reset_in_drop", in_drop, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_row(i, vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
